// File: rtl/llc_stage_fifo_if.sv
// Handshake/bus bundle for llc_stage_fifo; the FIFO takes the slave modport,
// the producer/consumer stage logic (or a bench) takes the master modport.
interface llc_stage_fifo_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  flush;
   logic                  push;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pop;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic [CNT_W-1:0]      usage;
   logic                  overflow_err;
   logic                  underflow_err;

   modport master (
      output flush, push, data_in, pop, err_clr,
      input  data_out, valid_out, full, empty, almost_full, usage,
             overflow_err, underflow_err
   );

   modport slave (
      input  flush, push, data_in, pop, err_clr,
      output data_out, valid_out, full, empty, almost_full, usage,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/llc_stage_fifo.sv
// Parametrised FWFT stage FIFO with flush, occupancy, almost-full and sticky error flags.
// Optional same-cycle bypass of an empty FIFO: define LLC_STAGE_FIFO_BYPASS_EN.
module llc_stage_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = DEPTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   llc_stage_fifo_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      usage_q, usage_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic empty_w, full_w;
   logic bypass;
   logic pop_acc, push_acc;
   logic ovf_evt, udf_evt;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_w = (usage_q == '0);
   assign full_w  = (usage_q == CNT_W'(DEPTH));

`ifdef LLC_STAGE_FIFO_BYPASS_EN
   assign bypass = empty_w & bus.push & bus.pop & ~bus.flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed packet is consumed on the spot, so it must neither be stored
   // nor count as an underflowing pop.
   assign pop_acc  = bus.pop & ~empty_w;
   assign push_acc = bus.push & (~full_w | pop_acc) & ~bypass;
   assign ovf_evt  = bus.push & ~push_acc & ~bypass & ~bus.flush;
   assign udf_evt  = bus.pop & empty_w & ~bypass & ~bus.flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usage_d  = usage_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         usage_d  = '0;
      end else begin
         if (push_acc) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = ptr_next(wr_ptr_q);
         end
         if (pop_acc) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
         end
         if (push_acc && !pop_acc) begin
            usage_d = usage_q + CNT_W'(1);
         end else if (pop_acc && !push_acc) begin
            usage_d = usage_q - CNT_W'(1);
         end
      end
      // A fresh error in the clearing cycle wins over err_clr.
      ovf_d = (ovf_q & ~bus.err_clr) | ovf_evt;
      udf_d = (udf_q & ~bus.err_clr) | udf_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usage_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usage_q  <= usage_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      if (bypass) begin
         bus.data_out = bus.data_in;
      end else if (empty_w) begin
         bus.data_out = '0;
      end else begin
         bus.data_out = mem_q[rd_ptr_q];
      end
   end

   assign bus.valid_out     = ~empty_w | bypass;
   assign bus.full          = full_w;
   assign bus.empty         = empty_w;
   assign bus.almost_full   = (usage_q >= CNT_W'(AF_THRESH));
   assign bus.usage         = usage_q;
   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_llc_stage_fifo.sv
// Directed bench for llc_stage_fifo: one DEPTH=4 and one DEPTH=3 instance share the
// stimulus and are compared every cycle against a list-based model of the FIFO.
module tb_llc_stage_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
   logic [7:0] din = 8'h00;

   int total = 0;
   int bad   = 0;

   llc_stage_fifo_if #(.DATA_WIDTH(8), .DEPTH(4)) if0 ();
   llc_stage_fifo_if #(.DATA_WIDTH(8), .DEPTH(3)) if1 ();

   assign if0.flush = flush;   assign if1.flush = flush;
   assign if0.push = push;     assign if1.push = push;
   assign if0.pop = pop;       assign if1.pop = pop;
   assign if0.err_clr = err_clr; assign if1.err_clr = err_clr;
   assign if0.data_in = din;   assign if1.data_in = din;

   llc_stage_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   llc_stage_fifo #(.DATA_WIDTH(8), .DEPTH(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   // {valid, data[7:0], full, empty, almost_full, usage[2:0], ovf, udf}
   logic [16:0] act0, act1;
   assign act0 = {if0.valid_out, if0.data_out, if0.full, if0.empty, if0.almost_full,
                  if0.usage, if0.overflow_err, if0.underflow_err};
   assign act1 = {if1.valid_out, if1.data_out, if1.full, if1.empty, if1.almost_full,
                  {1'b0, if1.usage}, if1.overflow_err, if1.underflow_err};

   // Model: an ordered list per instance, head at index 0.
   logic [7:0] mlist [2][8];
   int         mcnt [2] = '{0, 0};
   logic       movf [2] = '{1'b0, 1'b0};
   logic       mudf [2] = '{1'b0, 1'b0};

   function automatic int depth_of(input int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic logic byp_now(input int k);
`ifdef LLC_STAGE_FIFO_BYPASS_EN
      return (mcnt[k] == 0) && push && pop && !flush;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step(input int k);
      logic b, po, pu, ov, ud;
      b  = byp_now(k);
      ov = 1'b0;
      ud = 1'b0;
      if (flush) begin
         mcnt[k] = 0;
      end else begin
         po = pop && (mcnt[k] > 0);
         pu = push && ((mcnt[k] < depth_of(k)) || po) && !b;
         ov = push && !pu && !b;
         ud = pop && (mcnt[k] == 0) && !b;
         if (po) begin
            for (int i = 0; i < 7; i++) mlist[k][i] = mlist[k][i+1];
            mcnt[k] = mcnt[k] - 1;
         end
         if (pu) begin
            mlist[k][mcnt[k]] = din;
            mcnt[k] = mcnt[k] + 1;
         end
      end
      movf[k] = (movf[k] && !err_clr) || ov;
      mudf[k] = (mudf[k] && !err_clr) || ud;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   function automatic logic [16:0] expv(input int k);
      logic       b, v;
      logic [7:0] d;
      int         n, dp;
      b  = byp_now(k);
      n  = mcnt[k];
      dp = depth_of(k);
      v  = b || (n > 0);
      d  = b ? din : ((n > 0) ? mlist[k][0] : 8'h00);
      return {v, d, (n == dp), (n == 0), (n >= dp - 1), 3'(n), movf[k], mudf[k]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic pu, input logic [7:0] d, input logic po,
                     input logic fl, input logic ec);
      push = pu; din = d; pop = po; flush = fl; err_clr = ec;
      tick();
      push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      logic [7:0] v4 [4];
      logic [7:0] e4 [4];
      v4 = '{8'h11, 8'h22, 8'h33, 8'h44};
      e4 = '{8'h22, 8'h33, 8'h44, 8'h66};

      fork
         forever begin
            @(negedge clk);
            check("cyc_d4", 32'(act0), 32'(expv(0)));
            check("cyc_d3", 32'(act1), 32'(expv(1)));
         end
      join_none

      tick();
      check("reset_vec", 32'(act0), 32'h00040);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         op(1'b1, v4[i], 1'b0, 1'b0, 1'b0);
         check("fill_usage", 32'(if0.usage), i + 1);
         check("fill_af", 32'(if0.almost_full), (i >= 2) ? 1 : 0);
         check("fill_full", 32'(if0.full), (i == 3) ? 1 : 0);
      end

      op(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      check("ovf_set", 32'(if0.overflow_err), 1);
      check("ovf_usage", 32'(if0.usage), 4);
      op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_clr", 32'(if0.overflow_err), 0);

      for (int i = 0; i < 4; i++) begin
         check("drain_data", 32'(if0.data_out), 32'(v4[i]));
         op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      check("drain_empty", 32'(if0.empty), 1);

      for (int i = 0; i < 4; i++) op(1'b1, v4[i], 1'b0, 1'b0, 1'b0);
      op(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      check("fullpp_usage", 32'(if0.usage), 4);
      check("fullpp_ovf", 32'(if0.overflow_err), 0);
      for (int i = 0; i < 4; i++) begin
         check("fullpp_data", 32'(if0.data_out), 32'(e4[i]));
         op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end

      op(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
      op(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("ilv_data", 32'(if0.data_out), 32'(8'hA0 + 8'(i)));
         op(1'b1, 8'hA2 + 8'(i), 1'b1, 1'b0, 1'b0);
         check("ilv_usage", 32'(if0.usage), 2);
      end
      for (int i = 0; i < 2; i++) begin
         check("ilv_tail", 32'(if0.data_out), 32'(8'hAA + 8'(i)));
         op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end

      for (int i = 0; i < 3; i++) op(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
      check("pre_flush_af", 32'(if0.almost_full), 1);
      op(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      check("flush_usage", 32'(if0.usage), 0);
      check("flush_empty", 32'(if0.empty), 1);
      check("flush_ovf", 32'(if0.overflow_err), 0);
      op(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      check("post_flush_head", 32'(if0.data_out), 32'h01);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("udf_set", 32'(if0.underflow_err), 1);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      check("udf_clr_collide", 32'(if0.underflow_err), 1);
      op(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("udf_clr", 32'(if0.underflow_err), 0);

      push = 1'b1; din = 8'h88; pop = 1'b1;
      #1;
`ifdef LLC_STAGE_FIFO_BYPASS_EN
      check("byp_data", 32'(if0.data_out), 32'h88);
      check("byp_valid", 32'(if0.valid_out), 1);
      tick();
      push = 1'b0; pop = 1'b0;
      check("byp_usage", 32'(if0.usage), 0);
      check("byp_udf", 32'(if0.underflow_err), 0);
`else
      check("nobyp_valid", 32'(if0.valid_out), 0);
      tick();
      push = 1'b0; pop = 1'b0;
      check("nobyp_usage", 32'(if0.usage), 1);
      check("nobyp_udf", 32'(if0.underflow_err), 1);
      check("nobyp_head", 32'(if0.data_out), 32'h88);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("nobyp_empty", 32'(if0.empty), 1);
`endif

      op(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      op(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
      op(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("udf_before_rst", 32'(if0.underflow_err), 1);
      op(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
      op(1'b1, 8'hC5, 1'b0, 1'b0, 1'b0);
      check("pre_rst_usage", 32'(if0.usage), 2);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_vec", 32'(act0), 32'h00040);
      tick();
      rst = 1'b0;
      op(1'b1, 8'hD5, 1'b0, 1'b0, 1'b0);
      check("post_rst_usage", 32'(if0.usage), 1);
      check("post_rst_head", 32'(if0.data_out), 32'hD5);
      op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
